seq_detect_ctrl: RTL
====================

Name: seq_detect_ctrl

Overview:
Programmable serial-pattern detector controller for the Tiny Tapeout tile. It loads a 1–8 bit target pattern and pattern length, then consumes user-strobed serial bits. It flags each completed match with a one-cycle registered Mealy-style pulse and keeps a saturating match count. It is the configurable, sequenced successor to the fixed-sequence detector and presents the standard tt_um pin interface.

Parameters:
SYNC_STAGES, 2, synchronizer depth applied to ui_in and uio_in (fixed at 2 for this tile)
CNT_W, 5, match counter width (saturates at 2^CNT_W-1 = 31)

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset, sampled on rising clk
ena  input  1  tile enable; ignored by the logic
ui_in  input  8  [0]=serial data bit, [1]=bit strobe, [2]=cfg_load, [3]=overlap enable, [6:4]=pattern length-1, [7]=clear count
uio_in  input  8  target pattern, sampled on cfg_load
uo_out  output  8  [0]=match pulse, [1]=armed (RUN), [2]=count saturated, [7:3]=match count
uio_out  output  8  constant 0
uio_oe  output  8  constant 0 (all inputs)

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE, pattern=0, len=1, hist=0, fill=0, count=0, match=0, all sync/edge flops=0. uo_out=0x00 from the next cycle.
- ui_in and uio_in pass through a 2-flop synchronizer. Strobe, cfg_load and clear act on the rising edge of the synced bit, detected with a 3rd delay flop.
- Latency: raw ui_in[1] rises before edge E0 -> detected in cycle after E1 -> bit shifted at E2 -> match pulse high E2..E3. cfg_load and clear have the same 2-edge latency.
- States:
  - IDLE: strobes ignored; match=0, armed=0. cfg_load edge -> RUN.
  - RUN: armed=1. A cfg_load edge reloads the config and stays in RUN.
- Config load: pattern <= synced uio_in; len <= synced ui_in[6:4]+1 (range 1..8); hist <= 0; fill <= 0; count unchanged.
- Bit consume (RUN, strobe edge):
  - hist <= {hist[6:0], data}; fill <= min(fill+1, 8).
  - Pattern bit pattern[len-1] is the oldest bit; pattern[0] is the most recent bit.
- Match condition: fill_next >= len and hist_next[len-1:0] == pattern[len-1:0]. match is registered high for exactly one cycle.
- Overlap:
  - Synced ui_in[3] is sampled at the consume edge.
  - 1: history retained after a match (overlapping matches allowed).
  - 0: fill <= 0 on a match, so the next match needs len fresh bits.
- Count: +1 per match, saturating at 31; sat flag = (count==31).
- Priorities at the same edge:
  - cfg_load and strobe: load wins, bit discarded, no match.
  - clear and match: clear wins, count=0, match pulse still asserted.
  - clear works in IDLE and RUN.
- Strobe held high: consumes exactly one bit (edge-based).
- len change without cfg_load: no effect; length is latched only on load.
- Reset mid-RUN: immediate return to IDLE with full clear; strobes ignored until the next cfg_load.
- No combinational path from inputs to outputs; all uo_out bits are registered.

Test Plan:
1. Reset: rst_n=0 for 2 cycles with random ui_in/uio_in -> uo_out=0x00; strobes afterwards produce no match and armed=0 until cfg_load.
2. Overlap on: load uio_in=0x0B, ui_in[6:4]=3 (len 4), ui_in[3]=1. Feed 1,0,1,1,0,1,1 -> match pulses after bits 4 and 7, each 1 cycle wide at E2 latency; count=2, uo_out=0x12.
3. Overlap off: same load and stream with ui_in[3]=0 -> single match after bit 4; count=1.
4. Saturation: len 1, pattern 0x01, 35 strobes with data=1 -> 35 pulses, count stops at 31, uo_out[2]=1. Then clear -> count=0, sat=0.
5. Collisions:
   - cfg_load and strobe edges in the same cycle -> bit dropped, fill=0, no pulse.
   - clear coinciding with a match -> pulse seen, count=0.
6. Reset mid-RUN with a partial pattern shifted in -> IDLE, armed=0, count=0. Later strobes ignored; after reload the partial history does not cause a match.

Source files
------------

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: programmable 1-8 bit serial pattern detector with saturating match counter
module seq_detect_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_n;
    logic [SYNC_STAGES*8-1:0] ui_sr, uio_sr;
    logic [7:0] ui_s, uio_s, pattern, pattern_n, hist, hist_n, hist_sh, mask;
    logic [8:0] mask9;
    logic [2:0] ui_d;
    logic [3:0] len, len_n, fill, fill_n, fill_inc;
    logic [CNT_W-1:0] count, count_n;
    logic match, load, clr, consume, hit, sat, unused;
    assign ui_s     = ui_sr[SYNC_STAGES*8-1 -: 8];
    assign uio_s    = uio_sr[SYNC_STAGES*8-1 -: 8];
    assign load     = ui_s[2] & ~ui_d[1];
    assign clr      = ui_s[7] & ~ui_d[2];
    assign consume  = (state == RUN) & ui_s[1] & ~ui_d[0] & ~load;
    assign hist_sh  = {hist[6:0], ui_s[0]};
    assign fill_inc = (fill == 4'd8) ? fill : fill + 4'd1;
    assign mask9    = (9'd1 << len) - 9'd1;
    assign mask     = mask9[7:0];
    assign hit      = consume & (fill_inc >= len) & ((hist_sh & mask) == (pattern & mask));
    assign sat      = &count;
    assign unused   = ena;
    always_comb begin
        state_n   = load ? RUN : state;
        pattern_n = load ? uio_s : pattern;
        len_n     = load ? {1'b0, ui_s[6:4]} + 4'd1 : len;
        hist_n    = load ? 8'd0 : consume ? hist_sh : hist;
        fill_n    = load ? 4'd0 : consume ? ((hit & ~ui_s[3]) ? 4'd0 : fill_inc) : fill;
        count_n   = clr ? '0 : (hit & ~sat) ? count + CNT_W'(1) : count;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            ui_sr   <= '0;
            uio_sr  <= '0;
            ui_d    <= '0;
            pattern <= '0;
            len     <= 4'd1;
            hist    <= '0;
            fill    <= '0;
            count   <= '0;
            match   <= 1'b0;
        end else begin
            state   <= state_n;
            ui_sr   <= {ui_sr[SYNC_STAGES*8-9:0], ui_in};
            uio_sr  <= {uio_sr[SYNC_STAGES*8-9:0], uio_in};
            ui_d    <= {ui_s[7], ui_s[2], ui_s[1]};
            pattern <= pattern_n;
            len     <= len_n;
            hist    <= hist_n;
            fill    <= fill_n;
            count   <= count_n;
            match   <= hit;
        end
    end
    assign uo_out  = {count, sat, state == RUN, match};
    assign uio_out = 8'd0;
    assign uio_oe  = 8'd0;
endmodule
